// File: rtl/uart_pi_regs_if.sv
// PI register bus between the host processor (master) and the UART
// register block (slave).
interface uart_pi_regs_if;
  logic       pi_blk_sel;
  logic [3:0] pi_addr;
  logic       pi_wr_en;
  logic       pi_rd_en;
  logic [7:0] pi_wr_data;
  logic [7:0] pi_rd_data;

  modport master (
    output pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
    input  pi_rd_data
  );

  modport slave (
    input  pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
    output pi_rd_data
  );
endinterface

// File: rtl/uart_pi_regs.sv
// UART register block: PI bus decode, TX/RX byte FIFOs, status/control/divisor
// registers and the level interrupt request.
module uart_pi_regs_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   dropped
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  // A pop on a full FIFO frees the slot the concurrent push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_pi_regs #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RST    = 16'd27
) (
  input  logic           clk,
  input  logic           rst,
  uart_pi_regs_if.slave  pi,
  output logic           interrupt,
  input  logic           interrupt_ack,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [15:0]    baud_div
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en_q, rd_en_q, ack_q;
  logic          wr_fire, rd_fire, ack_fire, clr_flags, irq_set;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   div_q, div_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, irq_q, irq_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          tx_push, tx_pop, tx_full, tx_empty, tx_dropped, tx_going_empty;
  logic          rx_pop, rx_full, rx_empty, rx_dropped;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    rx_head;

  function automatic logic [7:0] lvl8(input logic [CW-1:0] c);
    logic [8:0] w;
    w = 9'(c);
    return w[8] ? 8'hFF : w[7:0];
  endfunction

  assign wr_fire  = pi.pi_blk_sel & pi.pi_wr_en & ~wr_en_q;
  assign rd_fire  = pi.pi_blk_sel & pi.pi_rd_en & ~rd_en_q;
  assign ack_fire = interrupt_ack & ~ack_q;

  assign tx_push  = wr_fire & (pi.pi_addr == 4'h0);
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_pop   = rd_fire & (pi.pi_addr == 4'h1);
  assign tx_going_empty = tx_pop & ~tx_push & (tx_count == CW'(1));

  uart_pi_regs_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(pi.pi_wr_data),
    .dout(tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty),
    .dropped(tx_dropped)
  );

  uart_pi_regs_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty),
    .dropped(rx_dropped)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    div_d     = div_q;
    clr_flags = 1'b0;
    if (wr_fire) begin
      case (pi.pi_addr)
        4'h3: begin
          ctrl_d    = pi.pi_wr_data[1:0];
          clr_flags = pi.pi_wr_data[7];
        end
        4'h4:    div_d[7:0]  = pi.pi_wr_data;
        4'h5:    div_d[15:8] = pi.pi_wr_data;
        default: ;
      endcase
    end
    // New overflows and new interrupt events win over same-cycle clears.
    tx_ovf_d = (tx_ovf_q & ~clr_flags) | tx_dropped;
    rx_ovf_d = (rx_ovf_q & ~clr_flags) | rx_dropped;
    irq_set  = (rx_valid & ~rx_dropped & ctrl_q[0]) | (tx_going_empty & ctrl_q[1]);
    irq_d    = irq_set | (irq_q & ~ack_fire);
  end

  always_comb begin
    rd_data_d = 8'h00;
    if (pi.pi_blk_sel) begin
      case (pi.pi_addr)
        4'h1:    rd_data_d = rx_empty ? 8'h00 : rx_head;
        4'h2:    rd_data_d = {1'b0, irq_q, rx_ovf_q, tx_ovf_q,
                              rx_empty, rx_full, tx_empty, tx_full};
        4'h3:    rd_data_d = {6'b0, ctrl_q};
        4'h4:    rd_data_d = div_q[7:0];
        4'h5:    rd_data_d = div_q[15:8];
        4'h6:    rd_data_d = lvl8(tx_count);
        4'h7:    rd_data_d = lvl8(rx_count);
        default: rd_data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ack_q     <= 1'b0;
      ctrl_q    <= 2'b00;
      div_q     <= DIV_RST;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      wr_en_q   <= pi.pi_wr_en;
      rd_en_q   <= pi.pi_rd_en;
      ack_q     <= interrupt_ack;
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign pi.pi_rd_data = rd_data_q;
  assign interrupt     = irq_q;
  assign tx_valid      = ~tx_empty;
  assign baud_div      = div_q;
endmodule

// File: tb/tb_uart_pi_regs.sv
// Bench for uart_pi_regs: directed scenarios plus a random register-access
// run checked against a queue-based model of the register block.
module tb_uart_pi_regs;
  localparam int          DEPTH   = 16;
  localparam logic [15:0] DIV_RST = 16'd27;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        interrupt, interrupt_ack, tx_valid, tx_ready, rx_valid;
  logic [7:0]  tx_data, rx_data;
  logic [15:0] baud_div;

  uart_pi_regs_if pi_bus();

  uart_pi_regs #(.FIFO_DEPTH(DEPTH), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst(rst), .pi(pi_bus),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .baud_div(baud_div)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_tx_ovf, m_rx_ovf, m_irq;
  logic [1:0]  m_ctrl;
  logic [15:0] m_div;

  function automatic void m_reset();
    m_tx.delete();
    m_rx.delete();
    m_tx_ovf = 1'b0;
    m_rx_ovf = 1'b0;
    m_irq    = 1'b0;
    m_ctrl   = 2'b00;
    m_div    = DIV_RST;
  endfunction

  function automatic logic [7:0] m_reg(input logic [3:0] a);
    case (a)
      4'h1: return (m_rx.size() != 0) ? m_rx[0] : 8'h00;
      4'h2: return {1'b0, m_irq, m_rx_ovf, m_tx_ovf, (m_rx.size() == 0),
                    (m_rx.size() == DEPTH), (m_tx.size() == 0), (m_tx.size() == DEPTH)};
      4'h3: return {6'b0, m_ctrl};
      4'h4: return m_div[7:0];
      4'h5: return m_div[15:8];
      4'h6: return 8'(m_tx.size());
      4'h7: return 8'(m_rx.size());
      default: return 8'h00;
    endcase
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [7:0] d);
    case (a)
      4'h0: if (m_tx.size() == DEPTH) m_tx_ovf = 1'b1; else m_tx.push_back(d);
      4'h3: begin
        m_ctrl = d[1:0];
        if (d[7]) begin m_tx_ovf = 1'b0; m_rx_ovf = 1'b0; end
      end
      4'h4: m_div[7:0]  = d;
      4'h5: m_div[15:8] = d;
      default: ;
    endcase
  endfunction

  function automatic void m_rx_in(input logic [7:0] d);
    if (m_rx.size() == DEPTH) m_rx_ovf = 1'b1;
    else begin
      m_rx.push_back(d);
      if (m_ctrl[0]) m_irq = 1'b1;
    end
  endfunction

  function automatic logic [7:0] m_tx_pop();
    logic [7:0] b;
    b = m_tx.pop_front();
    if (m_tx.size() == 0 && m_ctrl[1]) m_irq = 1'b1;
    return b;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pi_bus.pi_blk_sel = 1'b1; pi_bus.pi_addr = a; pi_bus.pi_wr_data = d; pi_bus.pi_wr_en = 1'b1;
    @(negedge clk);
    pi_bus.pi_wr_en = 1'b0; pi_bus.pi_blk_sel = 1'b0;
    m_write(a, d);
    @(negedge clk);
    $display("wr   addr=%h data=%02h", a, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] got, output logic [7:0] exp);
    @(negedge clk);
    exp = m_reg(a);
    pi_bus.pi_blk_sel = 1'b1; pi_bus.pi_addr = a; pi_bus.pi_rd_en = 1'b1;
    @(negedge clk);
    got = pi_bus.pi_rd_data;
    pi_bus.pi_rd_en = 1'b0; pi_bus.pi_blk_sel = 1'b0;
    if (a == 4'h1 && m_rx.size() != 0) void'(m_rx.pop_front());
    @(negedge clk);
    $display("rd   addr=%h data=%02h", a, got);
  endtask

  task automatic rx_in(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
    m_rx_in(d);
    $display("rx   data=%02h", d);
  endtask

  task automatic ack();
    @(negedge clk);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    m_irq = 1'b0;
    $display("ack");
  endtask

  logic [7:0] dr_got[$];
  logic [7:0] dr_exp[$];
  bit         dr_tmo;

  task automatic drain();
    int n;
    n = 0; dr_got.delete(); dr_exp.delete(); dr_tmo = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    while (tx_valid === 1'b1 && n < 4 * DEPTH) begin
      dr_got.push_back(tx_data);
      if (m_tx.size() != 0) dr_exp.push_back(m_tx_pop());
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    dr_tmo = (n >= 4 * DEPTH);
    while (m_tx.size() != 0) dr_exp.push_back(m_tx_pop());
    $display("tx   drained %0d bytes", dr_got.size());
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] g, e;
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    total++; if (pi_bus.pi_rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%02h exp=00", pi_bus.pi_rd_data); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (baud_div !== DIV_RST) begin bad++; $display("FAIL reset_baud got=%04h exp=%04h", baud_div, DIV_RST); end
    rst = 1'b1;
    rd(4'h2, g, e);
    total++; if (g !== 8'h0A) begin bad++; $display("FAIL reset_status got=%02h exp=0a", g); end
    rd(4'h4, g, e);
    total++; if (g !== 8'h1B) begin bad++; $display("FAIL reset_div_lo got=%02h exp=1b", g); end
    rd(4'h5, g, e);
    total++; if (g !== 8'h00) begin bad++; $display("FAIL reset_div_hi got=%02h exp=00", g); end
  endtask

  task automatic test_tx_fifo();
    logic [7:0] g, e;
    wr(4'h0, 8'h55);
    wr(4'h0, 8'hAA);
    rd(4'h6, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL txlvl got=%02h exp=%02h", g, e); end
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin bad++; $display("FAIL tx_head got=%b/%02h exp=1/55", tx_valid, tx_data); end
    drain();
    total++; if (dr_tmo || dr_got.size() != dr_exp.size()) begin bad++; $display("FAIL tx_drain_len got=%0d exp=%0d", dr_got.size(), dr_exp.size()); end
    foreach (dr_got[i]) if (i < dr_exp.size()) begin
      total++; if (dr_got[i] !== dr_exp[i]) begin bad++; $display("FAIL tx_order[%0d] got=%02h exp=%02h", i, dr_got[i], dr_exp[i]); end
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_valid_after got=%b exp=0", tx_valid); end
  endtask

  task automatic test_tx_irq();
    logic [7:0] g, e;
    wr(4'h3, 8'h02);
    wr(4'h0, 8'h5A);
    drain();
    total++; if (dr_got.size() != 1 || dr_got[0] !== 8'h5A) begin bad++; $display("FAIL tx_irq_byte got=%0d bytes exp=1 byte 5a", dr_got.size()); end
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL tx_irq_set got=%b exp=1", interrupt); end
    ack();
    @(negedge clk);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_ack got=%b exp=0", interrupt); end
    rd(4'h2, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL irq_status got=%02h exp=%02h", g, e); end
    wr(4'h3, 8'h00);
  endtask

  task automatic test_rx_overflow();
    logic [7:0] g, e;
    for (int i = 0; i <= DEPTH; i++) rx_in(8'(i));
    rd(4'h7, g, e);
    total++; if (g !== 8'(DEPTH)) begin bad++; $display("FAIL rxlvl_full got=%02h exp=%02h", g, 8'(DEPTH)); end
    rd(4'h2, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL rx_ovf_status got=%02h exp=%02h", g, e); end
    for (int i = 0; i <= DEPTH; i++) begin
      rd(4'h1, g, e);
      total++; if (g !== e) begin bad++; $display("FAIL rxdata[%0d] got=%02h exp=%02h", i, g, e); end
    end
    wr(4'h3, 8'h80);
    rd(4'h2, g, e);
    total++; if (g !== e || g[5] !== 1'b0) begin bad++; $display("FAIL clr_flags got=%02h exp=%02h", g, e); end
  endtask

  task automatic test_hold_strobe();
    logic [7:0] g, e;
    @(negedge clk);
    pi_bus.pi_blk_sel = 1'b1; pi_bus.pi_addr = 4'h0; pi_bus.pi_wr_data = 8'h3C; pi_bus.pi_wr_en = 1'b1;
    repeat (4) @(negedge clk);
    pi_bus.pi_wr_en = 1'b0; pi_bus.pi_blk_sel = 1'b0;
    m_write(4'h0, 8'h3C);
    $display("wr   addr=0 data=3c held 4 cycles");
    rd(4'h6, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL hold_txlvl got=%02h exp=%02h", g, e); end
    drain();
    total++; if (dr_tmo || dr_got.size() != dr_exp.size()) begin bad++; $display("FAIL hold_drain_len got=%0d exp=%0d", dr_got.size(), dr_exp.size()); end
  endtask

  task automatic test_blk_sel();
    logic [7:0] g, e;
    rx_in(8'h77);
    @(negedge clk);
    pi_bus.pi_blk_sel = 1'b0; pi_bus.pi_addr = 4'h0; pi_bus.pi_wr_data = 8'h11; pi_bus.pi_wr_en = 1'b1;
    @(negedge clk);
    total++; if (pi_bus.pi_rd_data !== 8'h00) begin bad++; $display("FAIL unsel_rd_data got=%02h exp=00", pi_bus.pi_rd_data); end
    pi_bus.pi_wr_en = 1'b0; pi_bus.pi_addr = 4'h1; pi_bus.pi_rd_en = 1'b1;
    @(negedge clk);
    pi_bus.pi_rd_en = 1'b0; pi_bus.pi_addr = 4'h4; pi_bus.pi_wr_data = 8'h99; pi_bus.pi_wr_en = 1'b1;
    @(negedge clk);
    pi_bus.pi_wr_en = 1'b0;
    @(negedge clk);
    $display("bus  strobes with blk_sel=0");
    rd(4'h6, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL unsel_txlvl got=%02h exp=%02h", g, e); end
    rd(4'h7, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL unsel_rxlvl got=%02h exp=%02h", g, e); end
    rd(4'h4, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL unsel_div got=%02h exp=%02h", g, e); end
    rd(4'h1, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL unsel_rxdata got=%02h exp=%02h", g, e); end
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] g, e, d;
    for (int i = 0; i < DEPTH; i++) wr(4'h0, 8'($urandom));
    rd(4'h6, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL full_txlvl got=%02h exp=%02h", g, e); end
    d = 8'($urandom);
    @(negedge clk);
    pi_bus.pi_blk_sel = 1'b1; pi_bus.pi_addr = 4'h0; pi_bus.pi_wr_data = d; pi_bus.pi_wr_en = 1'b1;
    tx_ready = 1'b1;
    g = tx_data;
    e = m_tx_pop();
    @(negedge clk);
    pi_bus.pi_wr_en = 1'b0; pi_bus.pi_blk_sel = 1'b0; tx_ready = 1'b0;
    m_write(4'h0, d);
    $display("wr   addr=0 data=%02h with tx pop of %02h", d, g);
    total++; if (g !== e) begin bad++; $display("FAIL simul_pop got=%02h exp=%02h", g, e); end
    rd(4'h6, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL simul_txlvl got=%02h exp=%02h", g, e); end
    rd(4'h2, g, e);
    total++; if (g !== e) begin bad++; $display("FAIL simul_status got=%02h exp=%02h", g, e); end
    drain();
    total++; if (dr_tmo || dr_got.size() != dr_exp.size()) begin bad++; $display("FAIL simul_drain_len got=%0d exp=%0d", dr_got.size(), dr_exp.size()); end
    foreach (dr_got[i]) if (i < dr_exp.size()) begin
      total++; if (dr_got[i] !== dr_exp[i]) begin bad++; $display("FAIL simul_order[%0d] got=%02h exp=%02h", i, dr_got[i], dr_exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] g, e, d;
    logic [3:0] a;
    for (int n = 0; n < 200; n++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 7))
        0: wr(4'h0, d);
        1: begin
          rd(4'h1, g, e);
          total++; if (g !== e) begin bad++; $display("FAIL rnd_rxdata got=%02h exp=%02h", g, e); end
        end
        2: rx_in(d);
        3: begin
          rd(4'h2, g, e);
          total++; if (g !== e) begin bad++; $display("FAIL rnd_status got=%02h exp=%02h", g, e); end
          total++; if (interrupt !== m_irq) begin bad++; $display("FAIL rnd_irq got=%b exp=%b", interrupt, m_irq); end
        end
        4: begin
          wr(4'h3, d);
          rd(4'h3, g, e);
          total++; if (g !== e) begin bad++; $display("FAIL rnd_ctrl got=%02h exp=%02h", g, e); end
        end
        5: begin
          a = 4'($urandom_range(4, 5));
          wr(a, d);
          rd(a, g, e);
          total++; if (g !== e) begin bad++; $display("FAIL rnd_div_reg got=%02h exp=%02h", g, e); end
          total++; if (baud_div !== m_div) begin bad++; $display("FAIL rnd_baud got=%04h exp=%04h", baud_div, m_div); end
        end
        6: begin
          a = 4'($urandom_range(6, 7));
          rd(a, g, e);
          total++; if (g !== e) begin bad++; $display("FAIL rnd_level got=%02h exp=%02h", g, e); end
        end
        default: begin
          if ($urandom_range(0, 1) == 0) ack();
          else begin
            a = 4'($urandom_range(8, 15));
            wr(a, d);
            rd(a, g, e);
            total++; if (g !== e) begin bad++; $display("FAIL rnd_unmapped got=%02h exp=%02h", g, e); end
          end
        end
      endcase
    end
    wr(4'h3, 8'h80);
    drain();
    total++; if (dr_tmo || dr_got.size() != dr_exp.size()) begin bad++; $display("FAIL rnd_drain_len got=%0d exp=%0d", dr_got.size(), dr_exp.size()); end
    foreach (dr_got[i]) if (i < dr_exp.size()) begin
      total++; if (dr_got[i] !== dr_exp[i]) begin bad++; $display("FAIL rnd_order[%0d] got=%02h exp=%02h", i, dr_got[i], dr_exp[i]); end
    end
    ack();
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] g, e;
    wr(4'h3, 8'h01);
    rx_in(8'h42);
    wr(4'h0, 8'h11);
    wr(4'h4, 8'h5A);
    total++; if (interrupt !== m_irq) begin bad++; $display("FAIL pre_reset_irq got=%b exp=%b", interrupt, m_irq); end
    @(negedge clk);
    pi_bus.pi_blk_sel = 1'b1; pi_bus.pi_addr = 4'h4;
    @(negedge clk);
    total++; if (pi_bus.pi_rd_data !== m_div[7:0]) begin bad++; $display("FAIL pre_reset_rd got=%02h exp=%02h", pi_bus.pi_rd_data, m_div[7:0]); end
    pi_bus.pi_wr_data = 8'hEE; pi_bus.pi_wr_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    $display("rst  asserted during write");
    total++; if (pi_bus.pi_rd_data !== 8'h00) begin bad++; $display("FAIL async_rd_data got=%02h exp=00", pi_bus.pi_rd_data); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL async_irq got=%b exp=0", interrupt); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL async_tx_valid got=%b exp=0", tx_valid); end
    total++; if (baud_div !== DIV_RST) begin bad++; $display("FAIL async_baud got=%04h exp=%04h", baud_div, DIV_RST); end
    @(negedge clk);
    pi_bus.pi_wr_en = 1'b0; pi_bus.pi_blk_sel = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    rd(4'h2, g, e);
    total++; if (g !== 8'h0A) begin bad++; $display("FAIL post_reset_status got=%02h exp=0a", g); end
    rd(4'h7, g, e);
    total++; if (g !== 8'h00) begin bad++; $display("FAIL post_reset_rxlvl got=%02h exp=00", g); end
    rd(4'h4, g, e);
    total++; if (g !== 8'h1B) begin bad++; $display("FAIL post_reset_div got=%02h exp=1b", g); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    pi_bus.pi_blk_sel = 1'b0;
    pi_bus.pi_addr    = 4'h0;
    pi_bus.pi_wr_en   = 1'b0;
    pi_bus.pi_rd_en   = 1'b0;
    pi_bus.pi_wr_data = 8'h00;
    interrupt_ack = 1'b0;
    tx_ready      = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;

    test_reset();
    test_tx_fifo();
    test_tx_irq();
    test_rx_overflow();
    test_hold_strobe();
    test_blk_sel();
    test_full_simultaneous();
    test_random();
    test_reset_mid_write();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_pi_regs.md
Name: uart_pi_regs

Overview:
- Responder (slave) side of the 8-bit processor-interface register bus (pi_*) that drives the UART.
- Decodes register reads and writes, and buffers bytes in a TX FIFO and an RX FIFO.
- Exposes status, control and baud divisor registers, and raises/acknowledges the interrupt.
- Sits between the PI bus and the UART tx/rx serializer cores.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; power of two, 2..256.
- DIV_RST, 16'd27, reset value of the baud divisor.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- pi_blk_sel  in  1  block select; qualifies all bus activity
- pi_addr  in  4  register address
- pi_wr_en  in  1  write strobe
- pi_rd_en  in  1  read strobe
- pi_wr_data  in  8  write data
- pi_rd_data  out  8  read data
- interrupt  out  1  interrupt request, level
- interrupt_ack  in  1  interrupt acknowledge
- tx_data  out  8  TX FIFO head byte to the serializer
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  serializer takes head byte when tx_valid & tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse: push rx_data
- baud_div  out  16  baud divisor to the cores

Behaviour:
- Reset (rst low, async):
  - FIFOs empty; all flags 0; CTRL=0x00; baud_div=DIV_RST.
  - pi_rd_data=0x00, interrupt=0, tx_valid=0.
  - Strobe edge detectors cleared.
- Strobe qualification:
  - Register wr_en/rd_en/interrupt_ack each cycle.
  - Action fires once, on the first cycle the strobe is sampled high while pi_blk_sel=1 (rising-edge detect).
  - A strobe held high for N cycles causes exactly one access.
  - Strobes with pi_blk_sel=0 are ignored.
- Read data: pi_rd_data is registered. Each cycle, when pi_blk_sel=1 it loads mux(pi_addr), else 0x00. Data is valid one cycle after pi_addr is stable and is held while selected.
- Register map (unlisted addresses read 0x00; writes to them are ignored):
  - 0x0 TXDATA, W: push pi_wr_data to the TX FIFO. If full, drop the byte and set tx_ovf.
  - 0x1 RXDATA, R: shows the RX head. The rd_en edge pops it. Empty: read 0x00, no pop, no flag.
  - 0x2 STATUS, R: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_ovf, [5] rx_ovf, [6] irq_pend, [7] 0.
  - 0x3 CTRL, R/W: [0] rx_irq_en, [1] tx_irq_en, [7] clr_flags. Writing [7]=1 clears tx_ovf/rx_ovf that cycle; [7] reads back 0.
  - 0x4 DIV_LO, R/W: baud_div[7:0].
  - 0x5 DIV_HI, R/W: baud_div[15:8].
  - 0x6 TXLVL, R: TX count (0..FIFO_DEPTH; saturates at 255 when depth is 256).
  - 0x7 RXLVL, R: RX count.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - Count is log2+1 bits.
  - Simultaneous push and pop:
    - Not full and not empty: count unchanged.
    - Full: the pop frees a slot, so the push is accepted and no overflow is flagged.
    - Empty: the pop is ignored and the push is accepted.
- TX core side:
  - tx_data = TX head, tx_valid = !tx_empty, both combinational from the FIFO.
  - A pop occurs on tx_valid & tx_ready.
- RX core side: rx_valid pushes rx_data. If full, drop the byte and set rx_ovf.
- Flag clear priority: if clr_flags and a new overflow occur in the same cycle, set wins.
- Interrupt:
  - irq_pend is set on either event:
    - an RX push while rx_irq_en=1;
    - the TX FIFO going non-empty to empty while tx_irq_en=1.
  - The interrupt_ack rising edge clears irq_pend. Ack works regardless of blk_sel.
  - Set and clear in the same cycle: set wins.
  - interrupt = irq_pend, registered.
  - Disabling an enable does not clear a pending interrupt.
- Latency:
  - Write takes effect on the clock edge following the strobe-edge sample.
  - Status and level registers reflect the change on the next read-mux load.

Test Plan:
- Reset, then read 0x2 -> 0x0A (tx_empty, rx_empty); read 0x4/0x5 -> 0x1B/0x00; interrupt=0.
- Write 0x0 with 0x55, 0xAA, tx_ready=0 -> TXLVL=2, tx_data=0x55. Raise tx_ready -> bytes leave in order 0x55, 0xAA; tx_valid drops.
- Write 0x3 with 0x02, push 1 byte, drain with tx_ready -> interrupt=1 on empty. Pulse interrupt_ack -> interrupt=0 next cycle; STATUS[6]=0.
- Pulse rx_valid FIFO_DEPTH+1 times with 0x00..0x10 -> RXLVL=16, STATUS[5]=1.
  - 16 reads of 0x1 -> 0x00..0x0F, 17th read returns 0x00.
  - Write CTRL 0x80 -> rx_ovf=0.
- Hold pi_wr_en high for 4 cycles on 0x0 -> exactly one push (TXLVL=1).
- Strobe with pi_blk_sel=0 -> no effect.
- TX FIFO full, then same-cycle register push and tx pop -> no tx_ovf, TXLVL stays 16.
- Assert rst mid-write -> all state returns to reset values immediately.
